// File: rtl/qupls_fpu_issue_sel.sv
// FPU issue selector: picks the oldest FPU-ready ROB entry, sequences RF read latency, offers it to the
// FPU station and holds off until completion. Define FPU_ISSUE_STATS_EN to add issue/stall counters.
module qupls_fpu_issue_sel #(
   parameter int unsigned ROB_ENTRIES = 32,
   parameter int unsigned RFREAD_LAT = 1,
   localparam int unsigned NdxW = $clog2(ROB_ENTRIES)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NdxW-1:0]        rob_head,
   input  logic [ROB_ENTRIES-1:0] fpu_ready,
   input  logic [ROB_ENTRIES-1:0] stomp,
   input  logic                   fpu_idle,
   input  logic                   sc_done,
   input  logic                   fpu_done,
   output logic [NdxW-1:0]        rndx,
   output logic                   rndxv,
   output logic                   available,
   output logic                   issue_v,
   output logic [NdxW-1:0]        issue_ndx,
   output logic                   busy
`ifdef FPU_ISSUE_STATS_EN
   ,
   output logic [31:0]            stat_issued,
   output logic [31:0]            stat_stall
`endif
);

   localparam int unsigned LatW = 2;

   typedef enum logic [1:0] {S_IDLE, S_RFRD, S_OFFER, S_BUSY} state_t;

   state_t                 state;
   logic [LatW-1:0]        latCnt;
   logic [ROB_ENTRIES-1:0] cand;
   logic [NdxW-1:0]        sel;
   logic [NdxW-1:0]        probe;
   logic                   anyCand;
   logic                   offerStomp;
   logic                   offerAccept;
   logic                   busyExit;

   assign cand        = fpu_ready & ~stomp;
   assign offerStomp  = stomp[rndx];
   assign offerAccept = (state == S_OFFER) && fpu_idle && !offerStomp;
   // A stomped in-flight op may only be abandoned once the FPU can take new work.
   assign busyExit    = sc_done | fpu_done | (stomp[issue_ndx] & fpu_idle);

   // Oldest-first scan starting at the ROB head, wrapping around the ROB.
   always_comb begin
      sel     = '0;
      probe   = '0;
      anyCand = 1'b0;
      for (int unsigned k = 0; k < ROB_ENTRIES; k++) begin
         probe = NdxW'((32'(rob_head) + k) % ROB_ENTRIES);
         if (!anyCand && cand[probe]) begin
            sel     = probe;
            anyCand = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         latCnt    <= '0;
         rndx      <= '0;
         rndxv     <= 1'b0;
         available <= 1'b0;
         issue_v   <= 1'b0;
         issue_ndx <= '0;
         busy      <= 1'b0;
      end
      else begin
         issue_v <= 1'b0;
         case (state)
            S_IDLE:
               if (anyCand) begin
                  rndx   <= sel;
                  rndxv  <= 1'b1;
                  latCnt <= LatW'(RFREAD_LAT);
                  if (RFREAD_LAT == 0) begin
                     available <= 1'b1;
                     state     <= S_OFFER;
                  end
                  else
                     state <= S_RFRD;
               end
            S_RFRD:
               if (offerStomp) begin
                  rndxv <= 1'b0;
                  state <= S_IDLE;
               end
               else if (latCnt <= LatW'(1)) begin
                  available <= 1'b1;
                  state     <= S_OFFER;
               end
               else
                  latCnt <= latCnt - LatW'(1);
            S_OFFER:
               if (offerStomp) begin
                  rndxv     <= 1'b0;
                  available <= 1'b0;
                  state     <= S_IDLE;
               end
               else if (fpu_idle) begin
                  issue_v   <= 1'b1;
                  issue_ndx <= rndx;
                  rndxv     <= 1'b0;
                  available <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_BUSY;
               end
            S_BUSY:
               if (busyExit) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            default:
               state <= S_IDLE;
         endcase
      end
   end

`ifdef FPU_ISSUE_STATS_EN
   // Saturating counters; issued count steps on the same edge that raises issue_v.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end
      else begin
         if (offerAccept && stat_issued != 32'hFFFFFFFF)
            stat_issued <= stat_issued + 32'd1;
         if (state == S_OFFER && !fpu_idle && stat_stall != 32'hFFFFFFFF)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
